mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning. ADDR_W, 8, memory address width. DATA_W, 8, memory data width.
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  req_valid  in  1  requester has a request.
  req_ready  out  1  controller accepts a request this cycle.
  req_write  in  1  1 = write, 0 = read.
  req_addr  in  ADDR_W  start address.
  req_wdata  in  DATA_W  write data.
  req_len  in  2  read burst beats minus 1; ignored for writes.
  rsp_valid  out  1  one-cycle pulse per completed beat.
  rsp_rdata  out  DATA_W  read data; 0 for write completions.
  rsp_last  out  1  qualifies rsp_valid on the final beat.
  busy  out  1  state != IDLE.
  mem_addr  out  ADDR_W  memory address.
  mem_we  out  1  memory write enable.
  mem_oe  out  1  memory output enable.
  mem_data  inout  DATA_W  shared memory data bus.

Function
REQ-003 FSM states SHALL be IDLE, WR, RD_ADDR and RD_DATA; req_ready SHALL be 1 only in IDLE.
REQ-004 Handshake: in IDLE with req_valid=1, the rising edge SHALL latch addr, write, wdata and len, then move to WR if req_write=1, else to RD_ADDR. req_valid outside IDLE SHALL be ignored.
REQ-005 mem_addr, mem_we and mem_oe SHALL be decoded from registered state and registers only; there SHALL be no combinational path from req_* to mem_*.
REQ-006 WR: one cycle, mem_we=1, mem_oe=0, mem_addr=latched addr, mem_data driven with latched wdata. Next edge: to IDLE, rsp_valid=1, rsp_last=1, rsp_rdata=0.
REQ-007 RD_ADDR: one cycle, mem_we=0, mem_oe=0, mem_addr=current addr; then to RD_DATA.
REQ-008 RD_DATA: one cycle, mem_we=0, mem_oe=1, same mem_addr. Next edge: mem_data captured into rsp_rdata, rsp_valid=1, rsp_last=1 if no beats remain.
REQ-009 After RD_DATA with beats remaining: beat count decrements, addr increments modulo 2^ADDR_W (all-ones wraps to 0), FSM returns to RD_ADDR; otherwise FSM goes to IDLE.
REQ-010 Latency: read beat data valid 2 cycles after accept edge, then every 2 cycles; write completion 1 cycle after accept edge.
REQ-011 mem_data SHALL be driven by mem_ctrl only while mem_we=1, otherwise high-Z; mem_oe and mem_we SHALL never both be 1.
REQ-012 rsp has no backpressure; the consumer SHALL take every rsp_valid pulse. rsp_valid SHALL be 0 in all other cycles; rsp_rdata holds its last value.
REQ-013 Back-to-back: a final-beat rsp_valid and a new acceptance in IDLE MAY occur in the same cycle.

Reset
REQ-014 While rst_n=0 (asynchronously): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_last=0, mem_addr=0, mem_we=0, mem_oe=0, mem_data high-Z, beat count=0.
REQ-015 Reset mid-transaction SHALL abort it; no rsp_valid for the aborted request after release.

Configuration
REQ-016 Macro MEM_CTRL_BURST_EN defined: read bursts of req_len+1 beats (1-4) per REQ-009.
REQ-017 MEM_CTRL_BURST_EN undefined: req_len treated as 0; every read is a single beat with rsp_last=1; ports unchanged.

Verification
REQ-018 Write 0x5A @0x10 -> exactly one cycle with mem_we=1, mem_addr=0x10, mem_data=0x5A; rsp_valid+rsp_last one cycle after accept.
REQ-019 Read @0x10 after REQ-018 -> rsp_rdata=0x5A, rsp_valid+rsp_last 2 cycles after accept; mem_oe=1 for exactly one cycle.
REQ-020 BURST_EN, memory FE/FF/00/01 = 11/22/33/44, read @0xFE len=3 -> rsp 11,22,33,44 every 2 cycles; mem_addr FE,FF,00,01; rsp_last only on 44. Without macro -> single rsp 11, rsp_last=1.
REQ-021 req_valid held high through a read -> second request accepted only at the cycle req_ready=1; no duplicate capture.
REQ-022 rst_n low during beat 2 of a 4-beat burst -> all outputs at reset values immediately, mem_data Z; no rsp_valid after release until a new request.
REQ-023 All scenarios: assert that mem_data is never driven by both mem_ctrl and memory (mem_we and mem_oe never both 1).

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Request/response bus between a requester and mem_ctrl.
// The requester uses the master modport; mem_ctrl uses the slave modport.
interface mem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_len;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_len,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_len,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: request/response controller for an asynchronous single-port memory with a shared data bus.
// Define MEM_CTRL_BURST_EN to enable read bursts of req_len+1 beats; otherwise every read is one beat.
module mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_oe,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic [1:0]        beats_r, beats_s;
  logic [1:0]        len_in_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic              rsp_last_r, rsp_last_s;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
  logic              mem_we_r, mem_oe_r;
  logic              ready_r, busy_r;

`ifdef MEM_CTRL_BURST_EN
  assign len_in_s = bus.req_len;
`else
  logic unused_len_s;
  assign len_in_s     = 2'd0;
  assign unused_len_s = ^bus.req_len;
`endif

  // Next-state, latch and response decode
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    beats_s     = beats_r;
    rsp_valid_s = 1'b0;
    rsp_last_s  = 1'b0;
    rsp_rdata_s = rsp_rdata_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          addr_s  = bus.req_addr;
          wdata_s = bus.req_wdata;
          beats_s = len_in_s;
          state_s = bus.req_write ? WR : RD_ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        state_s     = IDLE;
        rsp_valid_s = 1'b1;
        rsp_last_s  = 1'b1;
        rsp_rdata_s = {DATA_W{1'b0}};
      end
      RD_ADDR: begin
        state_s = RD_DATA;
      end
      RD_DATA: begin
        rsp_valid_s = 1'b1;
        rsp_rdata_s = mem_data;
        if (beats_r != 2'd0) begin
          // Address wraps naturally at the top of the address space
          beats_s    = beats_r - 2'd1;
          addr_s     = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_s    = RD_ADDR;
          rsp_last_s = 1'b0;
        end else begin
          state_s    = IDLE;
          rsp_last_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      beats_r     <= 2'd0;
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      mem_we_r    <= 1'b0;
      mem_oe_r    <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      beats_r     <= beats_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_last_r  <= rsp_last_s;
      rsp_rdata_r <= rsp_rdata_s;
      mem_we_r    <= (state_s == WR);
      mem_oe_r    <= (state_s == RD_DATA);
      ready_r     <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign mem_addr      = addr_r;
  assign mem_we        = mem_we_r;
  assign mem_oe        = mem_oe_r;
  assign mem_data      = mem_we_r ? wdata_r : {DATA_W{1'bz}};

  assign bus.req_ready = ready_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_last  = rsp_last_r;
  assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic against a
// cycle-timed reference model of a byte memory; honours MEM_CTRL_BURST_EN like the design.
`timescale 1ns/1ps
module tb_mem_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef MEM_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_oe;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0] tb_mem   [256];
  logic [DW-1:0] init_img [256];
  logic [DW-1:0] ref_mem  [256];
  logic          mem_init;
  int            chk_cnt = 0;
  int            err_cnt = 0;

  mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Asynchronous memory: drives the shared bus on output enable, writes at the clock edge
  assign mem_data = mem_oe ? tb_mem[mem_addr] : {DW{1'bz}};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_img[i];
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_data;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // The two bus drivers must never be enabled together
  always @(negedge clk) check_val("we_oe_excl", 32'(mem_we & mem_oe), 32'd0);

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] l);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_len   = l;
    check_val("ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
  endtask

  // Called right after the accept edge of a write
  task automatic write_phase(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit drop);
    @(negedge clk);
    if (drop) bus.req_valid = 1'b0;
    check_val("wr_we",      32'(mem_we), 32'd1);
    check_val("wr_oe",      32'(mem_oe), 32'd0);
    check_val("wr_addr",    32'(mem_addr), 32'(a));
    check_val("wr_data",    32'(mem_data), 32'(d));
    check_val("wr_rsp_early", 32'(bus.rsp_valid), 32'd0);
    check_val("wr_busy",    32'(bus.busy), 32'd1);
    check_val("wr_ready",   32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check_val("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_val("wr_rsp_last",  32'(bus.rsp_last), 32'd1);
    check_val("wr_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check_val("wr_we_off",    32'(mem_we), 32'd0);
    check_val("wr_idle",      32'(bus.busy), 32'd0);
    ref_mem[a] = d;
  endtask

  // Called right after the accept edge of a read; expects one beat every two cycles
  task automatic read_phase(input logic [AW-1:0] a, input logic [1:0] l, input bit drop);
    int beats;
    int b;
    logic [AW-1:0] ea;
    beats = BURST ? int'(l) + 1 : 1;
    for (int n = 0; n <= 2 * beats; n++) begin
      @(negedge clk);
      if (n == 0 && drop) bus.req_valid = 1'b0;
      check_val("rd_we", 32'(mem_we), 32'd0);
      check_val("rd_oe", 32'(mem_oe), 32'((n % 2 == 1) ? 1 : 0));
      check_val("rd_rsp_valid", 32'(bus.rsp_valid), 32'((n > 0 && n % 2 == 0) ? 1 : 0));
      if (n > 0 && n % 2 == 0) begin
        b  = n / 2 - 1;
        ea = a + AW'(b);
        check_val("rd_rdata", 32'(bus.rsp_rdata), 32'(ref_mem[ea]));
        check_val("rd_last",  32'(bus.rsp_last), 32'((b == beats - 1) ? 1 : 0));
      end
      if (n < 2 * beats) begin
        ea = a + AW'(n / 2);
        check_val("rd_addr",  32'(mem_addr), 32'(ea));
        check_val("rd_busy",  32'(bus.busy), 32'd1);
        check_val("rd_ready", 32'(bus.req_ready), 32'd0);
      end else begin
        check_val("rd_busy_end",  32'(bus.busy), 32'd0);
        check_val("rd_ready_end", 32'(bus.req_ready), 32'd1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_val({tag, "_rsp_last"},  32'(bus.rsp_last), 32'd0);
    check_val({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    check_val({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    check_val({tag, "_mem_we"},    32'(mem_we), 32'd0);
    check_val({tag, "_mem_oe"},    32'(mem_oe), 32'd0);
    check_val({tag, "_busy"},      32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] v;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    l;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = 2'd0;
    for (int i = 0; i < 256; i++) begin
      v = DW'($urandom);
      init_img[i] = v;
      ref_mem[i]  = v;
    end
    mem_init = 1'b1;
    rst_n    = 1'b0;
    #3;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    rst_n    = 1'b1;

    // Basic write then read-back of the same location
    issue(1'b1, 8'h10, 8'h5A, 2'd0);
    write_phase(8'h10, 8'h5A, 1'b1);
    issue(1'b0, 8'h10, 8'h00, 2'd0);
    read_phase(8'h10, 2'd0, 1'b1);

    // Burst across the top of the address space
    issue(1'b1, 8'hFE, 8'h11, 2'd0); write_phase(8'hFE, 8'h11, 1'b1);
    issue(1'b1, 8'hFF, 8'h22, 2'd0); write_phase(8'hFF, 8'h22, 1'b1);
    issue(1'b1, 8'h00, 8'h33, 2'd0); write_phase(8'h00, 8'h33, 1'b1);
    issue(1'b1, 8'h01, 8'h44, 2'd0); write_phase(8'h01, 8'h44, 1'b1);
    issue(1'b0, 8'hFE, 8'h00, 2'd3);
    read_phase(8'hFE, 2'd3, 1'b1);

    // req_valid held through a read; request fields switch to a write that must wait for IDLE
    issue(1'b0, 8'h20, 8'h00, 2'd1);
    #1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h40;
    bus.req_wdata = 8'hC3;
    bus.req_len   = 2'd0;
    read_phase(8'h20, 2'd1, 1'b0);
    @(posedge clk);
    write_phase(8'h40, 8'hC3, 1'b1);
    issue(1'b0, 8'h40, 8'h00, 2'd0);
    read_phase(8'h40, 2'd0, 1'b1);

    // Reset in the middle of a read aborts it
    issue(1'b0, 8'hFE, 8'h00, 2'd3);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (BURST ? 3 : 1) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    check_val("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check_val("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
      check_val("post_rst_busy", 32'(bus.busy), 32'd0);
    end

    // Randomized traffic against the reference memory
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom);
      d = DW'($urandom);
      l = 2'($urandom_range(0, 3));
      if (t % 5 == 0) a = 8'hFD;
      issue(w, a, d, l);
      if (w) write_phase(a, d, 1'b1);
      else   read_phase(a, l, 1'b1);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
